// File: rtl/save_clear_bank.sv
`default_nettype none
// ============================================================================
// Module      : save_clear_bank
// Description : Multi-channel save-and-clear capture bank. Each channel
//               detects a rising trigger edge, captures its counter value,
//               pulses a clear back to the counter, and queues
//               {channel, value} into a valid/ready FIFO. A sticky overflow
//               flags samples that were lost before they could be queued.
//               Optional macro SAVE_CLEAR_HOLDOFF_EN adds a per-channel
//               re-trigger lockout of HOLDOFF cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module save_clear_bank #(
  parameter int WIDTH    = 20,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8,
  parameter int HOLDOFF  = 4,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      fpga_clk_i,
  input  logic                      reset_i,
  input  logic [CHANNELS-1:0]       trigger_i,
  input  logic [CHANNELS*WIDTH-1:0] counter_val_i,
  output logic [CHANNELS-1:0]       counter_clear_o,
  output logic [CHANNELS*WIDTH-1:0] saved_val_o,
  output logic                      fifo_valid_o,
  input  logic                      fifo_ready_i,
  output logic [WIDTH-1:0]          fifo_data_o,
  output logic [CHAN_W-1:0]         fifo_chan_o,
  output logic [CNT_W-1:0]          fifo_count_o,
  output logic                      overflow_o,
  input  logic                      overflow_clr_i
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = CHAN_W + WIDTH;

  logic [CHANNELS-1:0]       trig_q;
  logic [CHANNELS-1:0]       pending_q;
  logic [CHANNELS-1:0]       clear_q;
  logic [CHANNELS*WIDTH-1:0] saved_q;
  logic                      overflow_q;
  logic [ENTRY_W-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]          count_q;

  logic [CHANNELS-1:0]       w_edge;
  logic [CHANNELS-1:0]       w_accept;
  logic [CHANNELS-1:0]       w_drained;
  logic [CHANNELS-1:0]       pending_d;
  logic                      w_drain_valid;
  logic [CHAN_W-1:0]         w_drain_idx;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_lost;

  assign w_edge = trigger_i & ~trig_q;

`ifdef SAVE_CLEAR_HOLDOFF_EN
  localparam int HO_W = $clog2(HOLDOFF + 1);

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_holdoff
      logic [HO_W-1:0] holdoff_q;

      // Lockout counter: loaded on capture, counts down to zero when idle
      always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
          holdoff_q <= '0;
        end else if (w_accept[k]) begin
          holdoff_q <= HO_W'(HOLDOFF);
        end else if (holdoff_q != '0) begin
          holdoff_q <= holdoff_q - 1'b1;
        end
      end

      assign w_accept[k] = w_edge[k] & (holdoff_q == '0);
    end
  endgenerate
`else
  // Without the lockout every edge captures; HOLDOFF is intentionally inert.
  logic [31:0] w_unused_holdoff;
  assign w_unused_holdoff = 32'(HOLDOFF);
  assign w_accept = w_edge;
`endif

  // Fixed-priority arbiter: lowest-index pending channel drains first
  always_comb begin
    w_drain_valid = 1'b0;
    w_drain_idx   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        w_drain_valid = 1'b1;
        w_drain_idx   = CHAN_W'(k);
      end
    end
  end

  assign w_pop  = fifo_valid_o & fifo_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push = w_drain_valid & ((count_q < CNT_W'(DEPTH)) | w_pop);

  // Pending bookkeeping; a new capture on the draining channel keeps it set,
  // and only a capture onto an undrained pending entry loses a sample.
  always_comb begin
    w_drained = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_drained[k] = w_push & (w_drain_idx == CHAN_W'(k));
    end
    pending_d = (pending_q & ~w_drained) | w_accept;
    w_lost    = |(w_accept & pending_q & ~w_drained);
  end

  // Edge history, captures, clear pulses, pending flags and sticky overflow
  always_ff @(posedge fpga_clk_i) begin
    trig_q <= trigger_i;
    if (reset_i) begin
      pending_q  <= '0;
      clear_q    <= '0;
      saved_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      clear_q   <= w_accept;
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_accept[k]) begin
          saved_q[k*WIDTH +: WIDTH] <= counter_val_i[k*WIDTH +: WIDTH];
        end
      end
      if (w_lost) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge fpga_clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {w_drain_idx, saved_q[w_drain_idx*WIDTH +: WIDTH]};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
      end
      if (w_pop) begin
        rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign counter_clear_o = clear_q;
  assign saved_val_o     = saved_q;
  assign overflow_o      = overflow_q;
  assign fifo_count_o    = count_q;
  assign fifo_valid_o    = (count_q != '0);
  assign fifo_data_o     = fifo_valid_o ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
  assign fifo_chan_o     = fifo_valid_o ? mem_q[rd_ptr_q][ENTRY_W-1:WIDTH] : '0;

endmodule
`default_nettype wire
